// File: rtl/rl_lj_position_loader.sv
// Position loader for the range-limited LJ force tile: streams ref/neighbor
// positions into the x/y/z RAM banks, then kicks the force pipeline and waits for done.
module rl_lj_position_loader #(
  parameter int unsigned DATA_WIDTH              = 32,
  parameter int unsigned REF_PARTICLE_NUM        = 100,
  parameter int unsigned REF_RAM_ADDR_WIDTH      = 7,
  parameter int unsigned NEIGHBOR_PARTICLE_NUM   = 100,
  parameter int unsigned NEIGHBOR_RAM_ADDR_WIDTH = 7
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               load_start,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic                               in_last,
  input  logic [DATA_WIDTH-1:0]              in_x,
  input  logic [DATA_WIDTH-1:0]              in_y,
  input  logic [DATA_WIDTH-1:0]              in_z,
  output logic                               ref_wren,
  output logic [REF_RAM_ADDR_WIDTH-1:0]      ref_wraddr,
  output logic                               nbr_wren,
  output logic [NEIGHBOR_RAM_ADDR_WIDTH-1:0] nbr_wraddr,
  output logic [DATA_WIDTH-1:0]              wr_x,
  output logic [DATA_WIDTH-1:0]              wr_y,
  output logic [DATA_WIDTH-1:0]              wr_z,
  output logic                               pipe_start,
  input  logic                               pipe_done,
  output logic                               busy,
  output logic                               batch_done,
  output logic                               len_error
);

  localparam int unsigned CNT_W = (REF_RAM_ADDR_WIDTH > NEIGHBOR_RAM_ADDR_WIDTH) ?
                                  REF_RAM_ADDR_WIDTH : NEIGHBOR_RAM_ADDR_WIDTH;
  localparam logic [CNT_W-1:0] REF_LAST = CNT_W'(REF_PARTICLE_NUM - 1);
  localparam logic [CNT_W-1:0] NBR_LAST = CNT_W'(NEIGHBOR_PARTICLE_NUM - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD_REF  = 3'd1,
    LOAD_NBR  = 3'd2,
    START     = 3'd3,
    WAIT_DONE = 3'd4
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  logic accept_c;
  logic ref_at_last_c;
  logic nbr_at_last_c;

  assign accept_c      = in_valid & in_ready;
  assign ref_at_last_c = (cnt == REF_LAST);
  assign nbr_at_last_c = (cnt == NBR_LAST);

  // A phase closes on in_last or on the final slot; any disagreement between the two is a length error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      in_ready   <= 1'b0;
      ref_wren   <= 1'b0;
      ref_wraddr <= '0;
      nbr_wren   <= 1'b0;
      nbr_wraddr <= '0;
      wr_x       <= '0;
      wr_y       <= '0;
      wr_z       <= '0;
      pipe_start <= 1'b0;
      busy       <= 1'b0;
      batch_done <= 1'b0;
      len_error  <= 1'b0;
    end else begin
      ref_wren   <= 1'b0;
      nbr_wren   <= 1'b0;
      pipe_start <= 1'b0;
      batch_done <= 1'b0;
      case (state)
        IDLE: begin
          if (load_start) begin
            state     <= LOAD_REF;
            cnt       <= '0;
            in_ready  <= 1'b1;
            busy      <= 1'b1;
            len_error <= 1'b0;
          end
        end
        LOAD_REF: begin
          if (accept_c) begin
            ref_wren   <= 1'b1;
            ref_wraddr <= REF_RAM_ADDR_WIDTH'(cnt);
            wr_x       <= in_x;
            wr_y       <= in_y;
            wr_z       <= in_z;
            if (in_last || ref_at_last_c) begin
              cnt   <= '0;
              state <= LOAD_NBR;
              if (in_last != ref_at_last_c) len_error <= 1'b1;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        LOAD_NBR: begin
          if (accept_c) begin
            nbr_wren   <= 1'b1;
            nbr_wraddr <= NEIGHBOR_RAM_ADDR_WIDTH'(cnt);
            wr_x       <= in_x;
            wr_y       <= in_y;
            wr_z       <= in_z;
            if (in_last || nbr_at_last_c) begin
              cnt      <= '0;
              in_ready <= 1'b0;
              state    <= START;
              if (in_last != nbr_at_last_c) len_error <= 1'b1;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        START: begin
          // Entered the cycle the last neighbor write is on the RAM port, so the pulse lands after it.
          pipe_start <= 1'b1;
          state      <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (pipe_done) begin
            batch_done <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rl_lj_position_loader.sv
// Scoreboard bench for rl_lj_position_loader: driver pushes expected RAM writes and
// pulses with their cycle numbers, a negedge monitor pops and compares.
module tb_rl_lj_position_loader;

  localparam int unsigned DW  = 32;
  localparam int unsigned RN  = 4;
  localparam int unsigned NN  = 3;
  localparam int unsigned RAW = 2;
  localparam int unsigned NAW = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           load_start = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_last = 1'b0;
  logic           pipe_done = 1'b0;
  logic [DW-1:0]  in_x = '0;
  logic [DW-1:0]  in_y = '0;
  logic [DW-1:0]  in_z = '0;
  logic           in_ready, ref_wren, nbr_wren, pipe_start, busy, batch_done, len_error;
  logic [RAW-1:0] ref_wraddr;
  logic [NAW-1:0] nbr_wraddr;
  logic [DW-1:0]  wr_x, wr_y, wr_z;

  rl_lj_position_loader #(
    .DATA_WIDTH(DW), .REF_PARTICLE_NUM(RN), .REF_RAM_ADDR_WIDTH(RAW),
    .NEIGHBOR_PARTICLE_NUM(NN), .NEIGHBOR_RAM_ADDR_WIDTH(NAW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .load_start(load_start),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .in_x(in_x), .in_y(in_y), .in_z(in_z),
    .ref_wren(ref_wren), .ref_wraddr(ref_wraddr),
    .nbr_wren(nbr_wren), .nbr_wraddr(nbr_wraddr),
    .wr_x(wr_x), .wr_y(wr_y), .wr_z(wr_z),
    .pipe_start(pipe_start), .pipe_done(pipe_done),
    .busy(busy), .batch_done(batch_done), .len_error(len_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind: 0 ref write, 1 nbr write, 2 pipe_start, 3 batch_done
  typedef struct {
    int            kind;
    int            addr;
    logic [DW-1:0] x, y, z;
    int            cyc;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  function automatic string kn(int k);
    case (k)
      0:       return "ref_wr";
      1:       return "nbr_wr";
      2:       return "pipe_start";
      default: return "batch_done";
    endcase
  endfunction

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(int kind, int addr, logic [DW-1:0] x, logic [DW-1:0] y,
                          logic [DW-1:0] z, int c);
    exp_t e;
    e.kind = kind; e.addr = addr; e.x = x; e.y = y; e.z = z; e.cyc = c;
    q.push_back(e);
  endtask

  task automatic see(int kind, int addr, logic [DW-1:0] x, logic [DW-1:0] y, logic [DW-1:0] z);
    exp_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL %s unexpected at cycle %0d addr=%0d", kn(kind), cyc, addr);
      return;
    end
    e = q.pop_front();
    if (e.kind != kind || e.cyc != cyc ||
        (kind < 2 && (e.addr != addr || e.x !== x || e.y !== y || e.z !== z))) begin
      errors++;
      $display("FAIL %s: got %s addr=%0d x=%h y=%h z=%h cyc=%0d, expected %s addr=%0d x=%h y=%h z=%h cyc=%0d",
               kn(e.kind), kn(kind), addr, x, y, z, cyc, kn(e.kind), e.addr, e.x, e.y, e.z, e.cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (ref_wren)   see(0, int'(ref_wraddr), wr_x, wr_y, wr_z);
      if (nbr_wren)   see(1, int'(nbr_wraddr), wr_x, wr_y, wr_z);
      if (pipe_start) see(2, 0, '0, '0, '0);
      if (batch_done) see(3, 0, '0, '0, '0);
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // last index per phase: -1 means in_last never asserted
  task automatic run_batch(int ref_last, int nbr_last, int stall_mode, bit nominal, int wait_cyc);
    bit exp_err;
    int e, num, lst, st, last_drive;
    exp_err    = 1'b0;
    last_drive = 0;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("in_ready_in_ref", in_ready, 1);
    chk("len_error_cleared", len_error, 0);
    for (int p = 0; p < 2; p++) begin
      num = (p == 0) ? RN : NN;
      lst = (p == 0) ? ref_last : nbr_last;
      e   = (lst >= 0 && lst < num - 1) ? lst : num - 1;
      if (lst != num - 1) exp_err = 1'b1;
      for (int i = 0; i <= e; i++) begin
        st = 0;
        if (stall_mode == 1 && $urandom_range(0, 3) == 0) st = int'($urandom_range(1, 3));
        else if (stall_mode == 2 && p == 0 && i == 2) st = 2;
        repeat (st) begin
          in_valid = 1'b0;
          in_x = $urandom;
          tick();
        end
        in_valid  = 1'b1;
        in_last   = (i == lst);
        in_x      = nominal ? 32'h3F80_0000 + DW'(i) : $urandom;
        in_y      = $urandom;
        in_z      = $urandom;
        pipe_done = (p == 0 && i == 0);
        push_exp(p, i, in_x, in_y, in_z, cyc + 1);
        last_drive = cyc;
        tick();
        pipe_done = 1'b0;
      end
    end
    push_exp(2, 0, '0, '0, '0, last_drive + 2);
    // a beat offered after the neighbor phase closed must be refused
    in_valid = 1'b1;
    in_last  = 1'b1;
    in_x     = $urandom;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("in_ready_after_load", in_ready, 0);
    repeat (wait_cyc) begin
      load_start = 1'($urandom_range(0, 1));
      tick();
    end
    load_start = 1'b0;
    chk("busy_waiting", busy, 1);
    chk("in_ready_waiting", in_ready, 0);
    chk("len_error_waiting", len_error, 128'(exp_err));
    pipe_done = 1'b1;
    push_exp(3, 0, '0, '0, '0, cyc + 1);
    tick();
    pipe_done = 1'b0;
    chk("busy_after_done", busy, 0);
    chk("len_error_after_done", len_error, 128'(exp_err));
    tick();
  endtask

  task automatic reset_mid_nbr();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_last  = (i == 3);
      in_x     = $urandom | 32'h1;
      in_y     = $urandom | 32'h1;
      in_z     = $urandom | 32'h1;
      push_exp((i < 4) ? 0 : 1, (i < 4) ? i : 0, in_x, in_y, in_z, cyc + 1);
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs",
        {ref_wren, nbr_wren, in_ready, busy, pipe_start, batch_done, len_error,
         ref_wraddr, nbr_wraddr, wr_x, wr_y, wr_z}, '0);
    q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    repeat (10) tick();
    chk("idle_after_reset_busy", busy, 0);
    chk("idle_after_reset_ready", in_ready, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("reset_state",
        {ref_wren, nbr_wren, in_ready, busy, pipe_start, batch_done, len_error,
         ref_wraddr, nbr_wraddr, wr_x, wr_y, wr_z}, '0);
    rst_n = 1'b1;
    tick();
    chk("idle_in_ready", in_ready, 0);

    run_batch(3, 2, 0, 1'b1, 3);    // nominal
    run_batch(3, 2, 2, 1'b0, 2);    // stall between ref beats 1 and 2
    run_batch(1, 2, 0, 1'b0, 2);    // early last in ref
    run_batch(3, -1, 0, 1'b0, 2);   // missing last in nbr
    run_batch(3, 2, 1, 1'b0, 50);   // long wait for done, load_start ignored
    for (int b = 0; b < 10; b++)
      run_batch(int'($urandom_range(0, 4)) - 1, int'($urandom_range(0, 3)) - 1, 1, 1'b0,
                int'($urandom_range(1, 6)));
    reset_mid_nbr();
    run_batch(3, 2, 1, 1'b0, 2);

    repeat (3) tick();
    chk("scoreboard_drained", 128'(q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/rl_lj_position_loader.md
Name: rl_lj_position_loader

Overview:
- Write-side front end for the range-limited LJ force tile. It accepts a streamed batch of reference and neighbor particle positions in IEEE-754 single precision, one particle per beat, over a valid/ready handshake.
- It writes the positions into the tile's reference and neighbor position RAMs (x/y/z banks) and then issues a one-cycle start pulse to the force pipeline.
- It holds off the next batch until the pipeline reports done, so the RAMs are never overwritten mid-evaluation.

Parameters:
- DATA_WIDTH, 32, width of one position coordinate (IEEE-754 single).
- REF_PARTICLE_NUM, 100, reference particles per batch.
- REF_RAM_ADDR_WIDTH, 7, ceil(log2(REF_PARTICLE_NUM)).
- NEIGHBOR_PARTICLE_NUM, 100, neighbor particles per batch.
- NEIGHBOR_RAM_ADDR_WIDTH, 7, ceil(log2(NEIGHBOR_PARTICLE_NUM)).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- load_start  in  1  pulse; begins a batch when the block is idle.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_last  in  1  marks the final beat of the current phase (ref or neighbor).
- in_x / in_y / in_z  in  DATA_WIDTH each  particle coordinates.
- ref_wren  out  1  write strobe shared by the ref x/y/z RAMs.
- ref_wraddr  out  REF_RAM_ADDR_WIDTH  ref RAM write address.
- nbr_wren  out  1  write strobe shared by the neighbor x/y/z RAMs.
- nbr_wraddr  out  NEIGHBOR_RAM_ADDR_WIDTH  neighbor RAM write address.
- wr_x / wr_y / wr_z  out  DATA_WIDTH each  write data, shared by both RAM sets.
- pipe_start  out  1  one-cycle start pulse to the force pipeline.
- pipe_done  in  1  done pulse from the force pipeline.
- busy  out  1  high in every state except IDLE.
- batch_done  out  1  one-cycle pulse when pipe_done is seen.
- len_error  out  1  sticky; a phase length did not match its parameter.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; in_ready, ref_wren, nbr_wren, pipe_start, batch_done, busy, len_error = 0; addresses, wr_x/y/z and counters = 0.
- Accept: a beat is accepted on a clock edge where in_valid & in_ready.
- States:
  - IDLE: in_ready=0. load_start=1 -> LOAD_REF, and len_error clears. Ignore load_start in every other state.
  - LOAD_REF: in_ready=1. Each accepted beat produces, on the next cycle: ref_wren=1, ref_wraddr=cnt, wr_*=beat data; then cnt++. The phase ends on an accepted beat with in_last=1, or on the beat with cnt=REF_PARTICLE_NUM-1, whichever comes first. Then cnt resets to 0 -> LOAD_NBR.
  - LOAD_NBR: same as LOAD_REF, using the nbr_* outputs and NEIGHBOR_PARTICLE_NUM. On phase end -> START.
  - START: in_ready=0. Assert pipe_start for exactly 1 cycle; this is the cycle after the last nbr_wren, so the final write has completed. Then -> WAIT_DONE.
  - WAIT_DONE: in_ready=0. On pipe_done=1: batch_done=1 for 1 cycle -> IDLE.
- Write latency: exactly 1 cycle from acceptance to wren. Back-to-back beats give one write per cycle with no bubbles.
- len_error (set, sticky until the next load_start):
  - in_last=1 on a beat with cnt < NUM-1 (early end); the phase still ends on that beat.
  - cnt reaches NUM-1 with in_last=0 (missing last); the phase still ends on that beat.
  - The pipeline is started regardless.
- in_valid=0 mid-phase: no write occurs; cnt holds; no timeout.
- pipe_done while not in WAIT_DONE: ignored.
- Reset mid-operation: immediate return to reset values; partial RAM contents are left as they are; pipe_start is never issued.
- Write addresses never wrap: each phase caps at NUM writes.

Test Plan (REF_PARTICLE_NUM=4, NEIGHBOR_PARTICLE_NUM=3):
- Nominal batch: load_start, then 4 ref beats (x=0x3F800000+i, last on i=3), then 3 nbr beats back-to-back -> ref_wren at addr 0..3 and nbr_wren at addr 0..2, each 1 cycle after its beat; pipe_start exactly 1 cycle after the nbr addr-2 write; len_error=0.
- Stalls: deassert in_valid for 2 cycles between ref beats 1 and 2 -> no extra writes; addresses remain contiguous 0..3.
- Early last: in_last on ref beat 1 -> 2 ref writes (addr 0,1); state moves to LOAD_NBR; len_error=1 and holds through batch_done.
- Missing last: 3 nbr beats with in_last=0 -> phase ends after addr 2; pipe_start issued; len_error=1. The next load_start clears it.
- Done handshake: pipe_done held low 50 cycles -> busy=1, in_ready=0, and load_start is ignored. A pipe_done pulse -> batch_done pulse the next cycle; state=IDLE.
- Async reset: assert rst_n=0 mid-LOAD_NBR, between edges -> outputs 0 immediately; no pipe_start follows after release.
